i2c_byte_shifter: RTL and testbench
===================================

Name: i2c_byte_shifter

Overview:
- Data-phase engine of the I2C master; sits directly upstream of the data-end/hold stage.
- Shifts one byte MSB-first on SDA, or samples one byte in, then runs the 9th (ACK) bit.
- Pulses `done` for one cycle; the controller FSM then enters its data-end state.
- Uses the same divisor-timed counter scheme as the rest of the controller: a phase ends when the counter equals `clock_divisor`, then the counter returns to 0.

Parameters:
- DIV_W, 16, width of the clock divisor and phase counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clock_divisor  in  DIV_W  phase length minus 1; latched on accepted start
- start  in  1  request a byte transfer; sampled only in IDLE
- rw  in  1  0 = write tx_byte, 1 = read into rx_byte; latched on start
- tx_byte  in  8  byte to transmit; latched on start
- ack_in  in  1  read only: 1 = master drives ACK (SDA low) in bit 9; latched on start
- scl_in  in  1  sensed SCL line, used for clock stretching
- sda_in  in  1  sensed SDA line
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rx_byte  out  8  received byte; valid from done, held until the next accepted start
- ack_out  out  1  sampled SDA in write bit 9 (0 = ACK); holds its last value otherwise

Behaviour:
- Reset: state IDLE, ctr = 0, bit_idx = 0.
  - Outputs: scl_oe = 0, sda_oe = 0, busy = 0, done = 0, rx_byte = 0, ack_out = 1.
  - Reset mid-transfer aborts immediately; the next cycle shows reset values on all outputs.
- States:
  - IDLE: lines released. If start = 1, latch divisor, rw, tx_byte and ack_in; set ctr = 0, bit_idx = 0; go to LOW. A start in any other state is ignored.
  - LOW: scl_oe = 1. sda_oe is driven per the SDA drive rule below from the first LOW cycle. When ctr == D, set ctr = 0 and go to HIGH; otherwise ctr = ctr + 1.
  - HIGH: scl_oe = 0, sda_oe unchanged.
    - If scl_in == 0, a slave is stretching: ctr holds and no sampling occurs.
    - On the cycle with ctr == D and scl_in == 1, sample sda_in, then:
      - bit_idx < 8 and read: shift into rx_byte LSB, shifting left.
      - bit_idx == 8 and write: ack_out <= sda_in.
    - After sampling, ctr = 0. If bit_idx == 8 go to DONE; else bit_idx + 1 and go to LOW.
  - DONE: done = 1 for exactly one cycle. scl_oe = 1 (SCL held low for the hold stage), sda_oe held. Next state is IDLE.
- SDA drive rule:
  - Write, bit_idx 0..7: sda_oe = ~tx_byte[7 - bit_idx]. Write, bit 8: sda_oe = 0.
  - Read, bits 0..7: sda_oe = 0. Read, bit 8: sda_oe = ack_in.
- Timing:
  - Each phase is D+1 cycles; one bit is 2(D+1) cycles.
  - A start sampled at cycle 0 gives LOW from cycle 1 and done at cycle 1 + 18(D+1), plus any stretch cycles.
  - D = 0 is legal: one cycle per phase.
  - D = all-ones: ctr reaches 16'hFFFF without overflow; the compare fires first.
- busy = (state != IDLE) && (state != DONE).
- Width rules: ctr is DIV_W bits; bit_idx is 4 bits, range 0..8.

Decomposition:
- Shared include i2c.vh gets:
  - new state localparams k_bit_low, k_bit_high, k_byte_done, alongside the existing k_data_end and k_hold;
  - K_ACK_BIT = 8;
  - DIV_W.
- One sub-module, i2c_phase_timer: DIV_W counter with `hold` input (stretch), `clear` input, and a `terminal` output (ctr == divisor).
- Step tasks go in test/steps/ for scl_oe, sda_oe, done and rx_byte, matching the existing ctr/state step files.

Test Plan:
- D=3, write 0xA5, sda_in=0 during bit 8 -> sda_oe sequence over LOW phases is 0,1,0,1,1,0,1,0 then 0; ack_out=0; done high at cycle 73 only; busy low at cycle 73.
- D=3, read with slave driving 0x3C, ack_in=0 -> rx_byte=0x3C at done; sda_oe=0 throughout, including bit 8.
- D=3, write 0xFF, scl_in forced low for 5 cycles in bit 3 HIGH -> ctr frozen for those cycles; done at cycle 78.
- D=0, write 0x00 -> sda_oe=1 for bits 0..7; done at cycle 19.
- Reset asserted at cycle 20 of a D=3 transfer -> cycle 21 shows scl_oe=0, sda_oe=0, busy=0, done=0, rx_byte=0; no done pulse ever appears.
- start held high throughout, D=1 -> second transfer latched only in the IDLE cycle after done; the first byte's latched data is unaffected.

Source files
------------

// File: rtl/i2c_byte_shifter_pkg.sv
// Shared types and constants for the I2C byte shifter.
package i2c_byte_shifter_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;
    localparam int unsigned BIT_IDX_W     = 4;
    localparam logic [BIT_IDX_W-1:0] K_ACK_BIT = 4'd8;

    typedef enum logic [1:0] {
        K_IDLE,
        K_BIT_LOW,
        K_BIT_HIGH,
        K_BYTE_DONE
    } shift_state_e;

    typedef struct packed {
        logic       rw;
        logic [7:0] tx_byte;
        logic       ack_in;
    } xfer_cfg_t;

    // SDA pull-down for a given bit slot: data bits on write, ACK slot on read.
    function automatic logic sda_drive(input xfer_cfg_t cfg, input logic [BIT_IDX_W-1:0] bit_idx);
        logic oe;
        if (bit_idx == K_ACK_BIT) begin
            oe = cfg.rw & cfg.ack_in;
        end else if (cfg.rw) begin
            oe = 1'b0;
        end else begin
            oe = ~cfg.tx_byte[3'(4'd7 - bit_idx)];
        end
        return oe;
    endfunction

endpackage

// File: rtl/i2c_byte_shifter_phase_timer.sv
// Divisor-timed phase counter: terminal when ctr equals divisor, then wraps to 0.
module i2c_phase_timer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             hold_i,
    input  logic             clear_i,
    output logic             terminal_c_o
);

    logic [DIV_W-1:0] ctr_q;
    logic [DIV_W-1:0] ctr_d;

    assign terminal_c_o = (ctr_q == divisor_i);

    // Compare fires before increment, so an all-ones divisor never overflows.
    always_comb begin
        ctr_d = ctr_q;
        if (clear_i) begin
            ctr_d = '0;
        end else if (!hold_i) begin
            ctr_d = terminal_c_o ? '0 : ctr_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/i2c_byte_shifter.sv
// I2C master data phase: 8 data bits MSB-first plus the ACK bit, with SCL stretching.
module i2c_byte_shifter
    import i2c_byte_shifter_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clock_divisor,
    input  logic             start,
    input  logic             rw,
    input  logic [7:0]       tx_byte,
    input  logic             ack_in,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rx_byte,
    output logic             ack_out
);

    shift_state_e         state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    xfer_cfg_t            cfg_q, cfg_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]           rx_q, rx_d;
    logic                 ack_out_q, ack_out_d;
    logic                 scl_oe_q, scl_oe_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clear_c;
    logic                 hold_c;
    logic                 terminal_c;

    i2c_phase_timer #(
        .DIV_W(DIV_W)
    ) u_phase_timer (
        .clk          (clk),
        .reset        (reset),
        .divisor_i    (div_q),
        .hold_i       (hold_c),
        .clear_i      (clear_c),
        .terminal_c_o (terminal_c)
    );

    // Next state plus next values of the registered line/status outputs.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cfg_d     = cfg_q;
        bit_idx_d = bit_idx_q;
        rx_d      = rx_q;
        ack_out_d = ack_out_q;
        sda_oe_d  = sda_oe_q;
        clear_c   = 1'b0;
        hold_c    = 1'b0;

        unique case (state_q)
            K_IDLE: begin
                clear_c  = 1'b1;
                sda_oe_d = 1'b0;
                if (start) begin
                    div_d     = clock_divisor;
                    cfg_d     = '{rw: rw, tx_byte: tx_byte, ack_in: ack_in};
                    bit_idx_d = '0;
                    sda_oe_d  = sda_drive(cfg_d, 4'd0);
                    state_d   = K_BIT_LOW;
                end
            end
            K_BIT_LOW: begin
                if (terminal_c) begin
                    state_d = K_BIT_HIGH;
                end
            end
            K_BIT_HIGH: begin
                // A slave holding SCL low freezes the phase counter.
                hold_c = ~scl_in;
                if (scl_in && terminal_c) begin
                    if (bit_idx_q == K_ACK_BIT) begin
                        if (!cfg_q.rw) begin
                            ack_out_d = sda_in;
                        end
                        state_d = K_BYTE_DONE;
                    end else begin
                        if (cfg_q.rw) begin
                            rx_d = {rx_q[6:0], sda_in};
                        end
                        bit_idx_d = bit_idx_q + 4'd1;
                        sda_oe_d  = sda_drive(cfg_q, bit_idx_d);
                        state_d   = K_BIT_LOW;
                    end
                end
            end
            K_BYTE_DONE: begin
                clear_c  = 1'b1;
                sda_oe_d = 1'b0;
                state_d  = K_IDLE;
            end
            default: begin
                state_d = K_IDLE;
            end
        endcase

        scl_oe_d = (state_d == K_BIT_LOW) || (state_d == K_BYTE_DONE);
        busy_d   = (state_d == K_BIT_LOW) || (state_d == K_BIT_HIGH);
        done_d   = (state_d == K_BYTE_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= K_IDLE;
            div_q     <= '0;
            cfg_q     <= '0;
            bit_idx_q <= '0;
            rx_q      <= '0;
            ack_out_q <= 1'b1;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cfg_q     <= cfg_d;
            bit_idx_q <= bit_idx_d;
            rx_q      <= rx_d;
            ack_out_q <= ack_out_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign scl_oe  = scl_oe_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_byte = rx_q;
    assign ack_out = ack_out_q;

endmodule

// File: tb/tb_i2c_byte_shifter.sv
// Bench for i2c_byte_shifter: timeline-based reference model, open-drain slave, directed and random transfers.
module tb_i2c_byte_shifter;

    logic        clk;
    logic        reset;
    logic [15:0] clock_divisor;
    logic        start;
    logic        rw;
    logic [7:0]  tx_byte;
    logic        ack_in;
    logic        scl_in;
    logic        sda_in;
    logic        scl_oe;
    logic        sda_oe;
    logic        busy;
    logic        done;
    logic [7:0]  rx_byte;
    logic        ack_out;

    i2c_byte_shifter #(.DIV_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .clock_divisor (clock_divisor),
        .start         (start),
        .rw            (rw),
        .tx_byte       (tx_byte),
        .ack_in        (ack_in),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .scl_oe        (scl_oe),
        .sda_oe        (sda_oe),
        .busy          (busy),
        .done          (done),
        .rx_byte       (rx_byte),
        .ack_out       (ack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a transfer is a timeline of 18*(D+1) counted cycles.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_d      = '0;
    logic        m_rw     = 1'b0;
    logic        m_ack    = 1'b0;
    logic [7:0]  m_tx     = '0;
    logic        e_scl, e_sda, e_busy, e_done, e_ack;
    logic [7:0]  e_rx;
    bit          chk_en   = 1'b0;

    function automatic logic drv(input int b);
        if (b < 8) return m_rw ? 1'b0 : ~m_tx[3'(7 - b)];
        return m_rw ? m_ack : 1'b0;
    endfunction

    always @(posedge clk) begin
        int ph;
        int plen;
        cyc++;
        plen = int'(m_d) + 1;
        if (reset) begin
            m_active = 1'b0; m_done = 1'b0; m_t = 0;
            e_scl = 1'b0; e_sda = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_rx = 8'h00; e_ack = 1'b1;
            chk_en = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
            e_done = 1'b0; e_busy = 1'b0; e_scl = 1'b0; e_sda = 1'b0;
        end else if (!m_active) begin
            e_scl = 1'b0; e_sda = 1'b0; e_busy = 1'b0;
            if (start) begin
                m_d = clock_divisor; m_rw = rw; m_tx = tx_byte; m_ack = ack_in;
                m_t = 0; m_active = 1'b1;
                e_scl = 1'b1; e_busy = 1'b1; e_sda = drv(0);
            end
        end else begin
            ph = m_t / plen;
            if (!((ph % 2 == 1) && !scl_in)) begin
                if ((ph % 2 == 1) && (m_t % plen == plen - 1)) begin
                    if (ph / 2 < 8 && m_rw) e_rx = {e_rx[6:0], sda_in};
                    if (ph / 2 == 8 && !m_rw) e_ack = sda_in;
                end
                m_t++;
            end
            if (m_t == 18 * plen) begin
                m_active = 1'b0; m_done = 1'b1;
                e_done = 1'b1; e_busy = 1'b0; e_scl = 1'b1;
            end else begin
                ph = m_t / plen;
                e_scl = (ph % 2 == 0); e_busy = 1'b1; e_sda = drv(ph / 2);
            end
        end
    end

    // Open-drain slave and stretcher, driven away from the active edge.
    logic [7:0] s_byte = '0;
    logic       s_ack  = 1'b0;
    int         st_bit = -1;
    int         st_rem = 0;

    always @(negedge clk) begin
        logic sv;
        int ph;
        int b;
        sv = 1'b1;
        scl_in = ~scl_oe;
        if (m_active) begin
            ph = m_t / (int'(m_d) + 1);
            b  = ph / 2;
            if (b < 8) sv = m_rw ? s_byte[3'(7 - b)] : 1'b1;
            else       sv = m_rw ? 1'b1 : s_ack;
            if ((ph % 2 == 1) && (b == st_bit) && (st_rem > 0)) begin
                scl_in = 1'b0;
                st_rem--;
            end
        end
        sda_in = sv & ~sda_oe;
    end

    // SDA value at the start of each LOW phase, newest in bit 0.
    logic [8:0] seq = '0;
    logic       prev_scl = 1'b0;
    always @(negedge clk) begin
        if (scl_oe === 1'b1 && prev_scl !== 1'b1 && busy === 1'b1) seq = {seq[7:0], sda_oe};
        prev_scl = scl_oe;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("scl_oe",  32'(scl_oe),  32'(e_scl));
            chk("sda_oe",  32'(sda_oe),  32'(e_sda));
            chk("busy",    32'(busy),    32'(e_busy));
            chk("done",    32'(done),    32'(e_done));
            chk("rx_byte", 32'(rx_byte), 32'(e_rx));
            chk("ack_out", 32'(ack_out), 32'(e_ack));
        end
    end

    task automatic run_xfer(input int d, input logic r, input logic [7:0] tx, input logic ak,
                            input logic [7:0] sb, input logic sa, input int sbit, input int slen,
                            output int lat);
        int s;
        int budget;
        @(negedge clk);
        clock_divisor = 16'(d); rw = r; tx_byte = tx; ack_in = ak;
        s_byte = sb; s_ack = sa; st_bit = sbit; st_rem = slen;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        rw = 1'($urandom); tx_byte = 8'($urandom); ack_in = 1'($urandom);
        clock_divisor = 16'($urandom);
        lat = -1;
        budget = 18 * (d + 1) + slen + 20;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                lat = cyc - s;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("done_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int lat;
        int s;
        int d1;
        int npulse;
        reset = 1'b1; start = 1'b0; rw = 1'b0; tx_byte = '0; ack_in = 1'b0; clock_divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe",  32'(scl_oe),  32'(0));
        chk("rst_ack_out", 32'(ack_out), 32'(1));
        reset = 1'b0;

        run_xfer(3, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, -1, 0, lat);
        chk("wr_a5_latency", 32'(lat), 32'(73));
        chk("wr_a5_sda_seq", 32'(seq), 32'(9'h0B4));
        chk("wr_a5_ack_out", 32'(ack_out), 32'(0));
        chk("wr_a5_busy_at_done", 32'(busy), 32'(0));

        run_xfer(3, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b1, -1, 0, lat);
        chk("rd_3c_latency", 32'(lat), 32'(73));
        chk("rd_3c_rx_byte", 32'(rx_byte), 32'(8'h3C));
        chk("rd_3c_sda_seq", 32'(seq), 32'(0));

        run_xfer(3, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 3, 5, lat);
        chk("stretch_latency", 32'(lat), 32'(78));

        run_xfer(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
        chk("d0_latency", 32'(lat), 32'(19));
        chk("d0_sda_seq", 32'(seq), 32'(9'h1FE));

        // Reset in the middle of a transfer.
        @(negedge clk);
        clock_divisor = 16'd3; rw = 1'b0; tx_byte = 8'h81; st_bit = -1; st_rem = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_scl_oe",  32'(scl_oe),  32'(0));
        chk("mid_rst_sda_oe",  32'(sda_oe),  32'(0));
        chk("mid_rst_busy",    32'(busy),    32'(0));
        chk("mid_rst_done",    32'(done),    32'(0));
        chk("mid_rst_rx_byte", 32'(rx_byte), 32'(0));
        chk("mid_rst_ack_out", 32'(ack_out), 32'(1));
        reset = 1'b0;
        npulse = 0;
        repeat (120) begin
            @(negedge clk);
            if (done === 1'b1) npulse++;
        end
        chk("mid_rst_no_done", 32'(npulse), 32'(0));

        // Start held high across back-to-back transfers, D=1.
        @(negedge clk);
        clock_divisor = 16'd1; rw = 1'b0; tx_byte = 8'h5A; ack_in = 1'b0;
        s_ack = 1'b1; st_bit = -1; st_rem = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        tx_byte = 8'hC3;
        d1 = -1;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin d1 = cyc; break; end
            @(negedge clk);
        end
        chk("held_first_latency", 32'(d1 - s), 32'(37));
        chk("held_first_sda_seq", 32'(seq), 32'(9'h14A));
        @(negedge clk);
        chk("held_idle_busy", 32'(busy), 32'(0));
        chk("held_idle_scl",  32'(scl_oe), 32'(0));
        @(negedge clk);
        start = 1'b0;
        chk("held_second_busy", 32'(busy), 32'(1));
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin lat = cyc - d1; break; end
            @(negedge clk);
        end
        chk("held_second_latency", 32'(lat), 32'(38));
        chk("held_second_sda_seq", 32'(seq), 32'(9'h078));

        // Random transfers with random stretching.
        for (int n = 0; n < 30; n++) begin
            int d;
            int sb;
            int sl;
            d  = int'($urandom_range(0, 4));
            sb = int'($urandom_range(0, 8));
            sl = int'($urandom_range(0, 6));
            run_xfer(d, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                     sb, sl, lat);
            chk("rand_latency", 32'(lat), 32'(1 + 18 * (d + 1) + sl));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
